// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, opcode values and the fetch-stage state encoding.
package cpu_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_LD  = 4'h3;
    localparam logic [3:0] OP_ST  = 4'h4;
    localparam logic [3:0] OP_BEQ = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register. Clear drops only the valid bit so a bubble keeps the last
// instruction/PC visible; clear beats load, hold freezes every field.
module ifid_reg #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               clear,
    input  logic               hold,
    input  logic [INSTR_W-1:0] next_instr,
    input  logic [ADDR_W-1:0]  next_pc_inc,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  pc_inc,
    output logic               valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr  <= '0;
            pc_inc <= '0;
            valid  <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (hold) begin
            valid <= valid;
        end else if (load) begin
            instr  <= next_instr;
            pc_inc <= next_pc_inc;
            valid  <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs the variable-latency imem handshake,
// and feeds the IF/ID register while honouring stall, redirect and HLT.
module if_stage #(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter logic [3:0]      OP_HLT   = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_valid,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc_inc,
    output logic               ifid_valid,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               hlt_fetched
);

    import cpu_pkg::*;

    fetch_state_e      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [ADDR_W-1:0] pend, pend_next;
    logic [ADDR_W-1:0] pc_inc;
    logic              is_hlt;
    logic              reg_load, reg_clear, reg_hold;

    // PC+2 wraps silently at the top of the address space.
    assign pc_inc = pc + ADDR_W'(2);
    assign is_hlt = (imem_data[INSTR_W-1 -: 4] == OP_HLT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            pc    <= RESET_PC;
            pend  <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            pend  <= pend_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        pend_next  = pend;
        reg_load   = 1'b0;
        reg_clear  = 1'b0;
        reg_hold   = 1'b0;
        imem_req   = 1'b1;
        unique case (state)
            ST_RUN: begin
                if (redirect) begin
                    reg_clear = 1'b1;
                    if (imem_valid) begin
                        pc_next = redirect_pc;
                    end else begin
                        // The outstanding fetch must still complete before the new address goes out.
                        pend_next  = redirect_pc;
                        state_next = ST_DRAIN;
                    end
                end else if (stall) begin
                    reg_hold = 1'b1;
                end else if (imem_valid) begin
                    reg_load = 1'b1;
                    if (is_hlt) begin
                        state_next = ST_HALT;
                    end else begin
                        pc_next = pc_inc;
                    end
                end else begin
                    reg_clear = 1'b1;
                end
            end
            ST_DRAIN: begin
                reg_clear = 1'b1;
                if (redirect) begin
                    pend_next = redirect_pc;
                end
                if (imem_valid) begin
                    pc_next    = redirect ? redirect_pc : pend;
                    state_next = ST_RUN;
                end
            end
            ST_HALT: begin
                imem_req  = 1'b0;
                reg_clear = 1'b1;
                if (redirect) begin
                    pc_next    = redirect_pc;
                    state_next = ST_RUN;
                end
            end
            default: begin
                reg_clear  = 1'b1;
                state_next = ST_RUN;
            end
        endcase
    end

    assign imem_addr   = pc;
    assign pc_out      = pc;
    assign hlt_fetched = (state == ST_HALT);

    ifid_reg #(
        .ADDR_W (ADDR_W),
        .INSTR_W(INSTR_W)
    ) u_ifid_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (reg_load),
        .clear      (reg_clear),
        .hold       (reg_hold),
        .next_instr (imem_data),
        .next_pc_inc(pc_inc),
        .instr      (ifid_instr),
        .pc_inc     (ifid_pc_inc),
        .valid      (ifid_valid)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: the bench plays instruction memory and checks each step
// against hand-computed values with immediate assertions.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_valid = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_inc;
    logic        ifid_valid;
    logic [15:0] pc_out;
    logic        hlt_fetched;

    int n_asserts = 0;
    int n_fails   = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .imem_valid (imem_valid),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .ifid_instr (ifid_instr),
        .ifid_pc_inc(ifid_pc_inc),
        .ifid_valid (ifid_valid),
        .pc_out     (pc_out),
        .hlt_fetched(hlt_fetched)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset asserted mid-cycle takes effect at once
        #3 rst = 1'b1;
        #1;
        check("rst_pc", pc_out, 16'h0000);
        check("rst_valid", ifid_valid, 1'b0);
        check("rst_hlt", hlt_fetched, 1'b0);
        check("rst_instr", ifid_instr, 16'h0000);
        step();
        step();
        rst = 1'b0;
        #1;
        check("post_rst_req", imem_req, 1'b1);
        check("post_rst_addr", imem_addr, 16'h0000);

        // Zero-wait fetch
        imem_valid = 1'b1;
        imem_data  = 16'h1123;
        step();
        check("zw1_instr", ifid_instr, 16'h1123);
        check("zw1_pcinc", ifid_pc_inc, 16'h0002);
        check("zw1_valid", ifid_valid, 1'b1);
        check("zw1_pc", pc_out, 16'h0002);
        imem_data = 16'h2456;
        step();
        check("zw2_instr", ifid_instr, 16'h2456);
        check("zw2_pcinc", ifid_pc_inc, 16'h0004);
        check("zw2_pc", pc_out, 16'h0004);

        // Three-cycle miss at 0004
        imem_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("miss_addr", imem_addr, 16'h0004);
            check("miss_valid", ifid_valid, 1'b0);
        end
        imem_valid = 1'b1;
        imem_data  = 16'h3789;
        step();
        check("miss_instr", ifid_instr, 16'h3789);
        check("miss_valid_done", ifid_valid, 1'b1);
        check("miss_pc", pc_out, 16'h0006);

        // Two-cycle stall with responses arriving: everything holds
        stall     = 1'b1;
        imem_data = 16'h4AAA;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_instr", ifid_instr, 16'h3789);
            check("stall_pcinc", ifid_pc_inc, 16'h0006);
            check("stall_valid", ifid_valid, 1'b1);
            check("stall_pc", pc_out, 16'h0006);
        end
        stall = 1'b0;
        step();
        check("unstall_instr", ifid_instr, 16'h4AAA);
        check("unstall_pcinc", ifid_pc_inc, 16'h0008);
        check("unstall_pc", pc_out, 16'h0008);

        // Redirect during a miss at 0008 -> DRAIN until the stale response lands
        imem_valid  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        step();
        check("drain1_valid", ifid_valid, 1'b0);
        check("drain1_addr", imem_addr, 16'h0008);
        check("drain1_req", imem_req, 1'b1);
        redirect = 1'b0;
        step();
        check("drain2_valid", ifid_valid, 1'b0);
        check("drain2_addr", imem_addr, 16'h0008);
        imem_valid = 1'b1;
        imem_data  = 16'h5BBB;
        step();
        check("drain_end_valid", ifid_valid, 1'b0);
        check("drain_end_instr", ifid_instr, 16'h4AAA);
        check("drain_end_addr", imem_addr, 16'h0040);

        // Redirect wins over stall and a same-cycle hit
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h000A;
        step();
        check("redir_stall_valid", ifid_valid, 1'b0);
        check("redir_stall_pc", pc_out, 16'h000A);
        stall    = 1'b0;
        redirect = 1'b0;

        // HLT at 000A
        imem_data = 16'hF000;
        step();
        check("hlt_valid", ifid_valid, 1'b1);
        check("hlt_instr", ifid_instr, 16'hF000);
        check("hlt_pcinc", ifid_pc_inc, 16'h000C);
        check("hlt_pc", pc_out, 16'h000A);
        check("hlt_flag", hlt_fetched, 1'b1);
        check("hlt_req", imem_req, 1'b0);
        imem_valid = 1'b0;
        step();
        check("halted_valid", ifid_valid, 1'b0);
        check("halted_instr", ifid_instr, 16'hF000);
        check("halted_pc", pc_out, 16'h000A);
        check("halted_flag", hlt_fetched, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 16'h0020;
        step();
        check("unhalt_flag", hlt_fetched, 1'b0);
        check("unhalt_addr", imem_addr, 16'h0020);
        check("unhalt_req", imem_req, 1'b1);

        // PC wrap from FFFE
        redirect_pc = 16'hFFFE;
        imem_valid  = 1'b1;
        step();
        check("wrap_pc_set", pc_out, 16'hFFFE);
        redirect  = 1'b0;
        imem_data = 16'h1111;
        step();
        check("wrap_pcinc", ifid_pc_inc, 16'h0000);
        check("wrap_pc", pc_out, 16'h0000);
        check("wrap_instr", ifid_instr, 16'h1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the pipelined CPU, sitting directly upstream of decode/register read. It owns the PC and drives a variable-latency instruction-memory port with a valid handshake, so cache misses are absorbed here. It produces the IF/ID pipeline register (instruction, PC+2, valid). It honours stall requests from the hazard unit and PC redirects from branch resolution in decode, and it stops fetching after a HLT.

Parameters:
ADDR_W, 16, PC and instruction-memory address width
INSTR_W, 16, instruction width
RESET_PC, 16'h0000, PC value after reset
OP_HLT, 4'hF, opcode (instr[15:12]) that halts fetch

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address (always equals current PC)
imem_data  in  INSTR_W  fetched instruction; meaningful only when imem_valid=1
imem_valid  in  1  fetch completes this cycle; may be high in the same cycle as the request (hit)
stall  in  1  hazard unit: hold IF/ID and PC
redirect  in  1  branch/jump taken in decode; squash the younger fetch
redirect_pc  in  ADDR_W  redirect target
ifid_instr  out  INSTR_W  IF/ID instruction
ifid_pc_inc  out  ADDR_W  IF/ID PC+2
ifid_valid  out  1  IF/ID holds a real instruction (0 means bubble)
pc_out  out  ADDR_W  current PC (debug/testbench)
hlt_fetched  out  1  high while the stage is in HALT

Behaviour:
- Reset (async, rst=1):
  - PC=RESET_PC; state=RUN.
  - ifid_instr=0, ifid_pc_inc=0, ifid_valid=0.
  - Pending-target register=0; hlt_fetched=0.
  - Any in-flight fetch is abandoned, and the memory is reset with it.
- Memory contract:
  - While imem_req=1, imem_addr stays constant until the cycle in which imem_valid=1.
  - A completed handshake consumes exactly one response.
- States:
  - RUN: imem_req=1, imem_addr=PC.
  - DRAIN: imem_req=1, imem_addr=PC (the old address). A redirect is pending; the in-flight response is discarded.
  - HALT: imem_req=0.
- RUN priority, evaluated per cycle:
  1. redirect=1
     - ifid_valid<=0, regardless of stall.
     - If imem_valid=1: PC<=redirect_pc, stay in RUN.
     - Else: pend<=redirect_pc, go to DRAIN.
  2. stall=1
     - IF/ID holds all fields; PC holds.
     - If imem_valid=1, the data is dropped and the same PC is re-fetched next cycle. No instruction is skipped or duplicated.
  3. imem_valid=1
     - ifid_instr<=imem_data, ifid_pc_inc<=PC+2, ifid_valid<=1.
     - If imem_data[15:12]==OP_HLT: PC holds and the stage goes to HALT.
     - Otherwise PC<=PC+2.
  4. Otherwise (miss in progress): ifid_valid<=0 (bubble); PC holds.
- DRAIN:
  - ifid_valid<=0 every cycle.
  - A further redirect overwrites pend.
  - On imem_valid=1: response discarded, PC<=pend (or redirect_pc if redirect=1 in the same cycle), go to RUN.
  - stall is ignored.
- HALT:
  - ifid_valid<=0 from the cycle after the HLT loads; IF/ID instr and pc_inc hold their values.
  - redirect=1 (an older branch was taken, squashing the HLT): PC<=redirect_pc, go to RUN.
- Arithmetic: PC+2 is modulo 2^ADDR_W, so 16'hFFFE+2 wraps to 16'h0000 with no flag.
- Outputs: pc_out=PC combinationally; hlt_fetched=(state==HALT).
- Unused state encoding: the next state is RUN.

Decomposition:
- Shared package cpu_pkg holds:
  - the INSTR_W and ADDR_W constants;
  - opcode constants, including OP_HLT;
  - the fetch-state encoding (RUN=2'd0, DRAIN=2'd1, HALT=2'd2).
- One sub-module, ifid_reg:
  - IF/ID pipeline register;
  - inputs load, clear, hold;
  - async-reset fields instr, pc_inc, valid; clear has priority over load.
- The FSM and PC logic stay in if_stage.

Test Plan:
- Reset: assert rst mid-cycle -> immediately pc_out=0000, ifid_valid=0, hlt_fetched=0. After release: imem_req=1, imem_addr=0000.
- Zero-wait fetch: imem_valid=1 every cycle, data 1123, 2456 -> after edge 1: ifid_instr=1123, ifid_pc_inc=0002, pc_out=0002. After edge 2: ifid_instr=2456, pc_out=0004.
- Miss:
  - Stimulus: at PC=0004, imem_valid=0 for 3 cycles, then data 3789.
  - Response: imem_addr stays 0004 and ifid_valid=0 for 3 cycles, then ifid_instr=3789 and pc_out=0006.
- Stall:
  - Stimulus: stall=1 for 2 cycles with imem_valid=1.
  - Response: IF/ID unchanged and pc_out unchanged. After stall drops, the instruction at the held PC loads once.
- Redirect during miss:
  - Stimulus: at PC=0008, redirect=1 with redirect_pc=0040, imem_valid=0. The response arrives 2 cycles later.
  - Response: DRAIN with imem_addr=0008 throughout and ifid_valid=0. The old data is discarded; the next request is to 0040.
- Halt:
  - Stimulus: fetch F000 at PC=000A.
  - Response: ifid_valid=1 for one cycle, then 0; imem_req=0, pc_out=000A, hlt_fetched=1.
  - Then redirect=1 with redirect_pc=0020 -> RUN, imem_addr=0020, hlt_fetched=0.
